// File: rtl/znd_pkg.sv
// Shared types for the probe firing scheduler: FSM states, table entry layout,
// the acquisition timeout default and the burst-target rule.
package znd_pkg;

    localparam int FW         = 8;
    localparam int TOW        = 12;
    localparam int ACQ_TO_DEF = 4095;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT_ACQ,
        NEXT
    } znd_state_e;

    typedef struct packed {
        logic [FW-1:0] frq;
        logic [FW-1:0] pw;
        logic [FW-1:0] burst;
        logic          en;
    } znd_ent_t;

    // A programmed burst of zero still fires one probe period.
    function automatic logic [FW-1:0] burst_tgt(input logic [FW-1:0] b);
        return (b == '0) ? FW'(1) : b;
    endfunction

endpackage

// File: rtl/znd_ch_tbl.sv
// Per-channel settings table: write port, combinational read at ch_i, and the
// lowest-enabled / next-enabled-above priority encoders over the live table.
module znd_ch_tbl
    import znd_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic           clk250,
    input  logic           rst_n,
    input  logic           we_i,
    input  logic [CHW-1:0] waddr_i,
    input  znd_ent_t       wdat_i,
    input  logic [CHW-1:0] ch_i,
    output logic [FW-1:0]  rd_frq_o,
    output logic [FW-1:0]  rd_pw_o,
    output logic [FW-1:0]  rd_burst_o,
    output logic           nxt_vld_o,
    output logic [CHW-1:0] nxt_idx_o,
    output logic [CHW-1:0] low_idx_o,
    output logic           any_en_o
);

    znd_ent_t tbl_q [NCH];

    always_ff @(posedge clk250 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 0; i < NCH; i++) begin
                if (waddr_i == CHW'(i)) begin
                    tbl_q[i] <= wdat_i;
                end
            end
        end
    end

    // Descending scan so the last hit (the lowest index) wins both encoders.
    always_comb begin
        rd_frq_o   = '0;
        rd_pw_o    = '0;
        rd_burst_o = '0;
        nxt_vld_o  = 1'b0;
        nxt_idx_o  = '0;
        low_idx_o  = '0;
        any_en_o   = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_i == CHW'(i)) begin
                rd_frq_o   = tbl_q[i].frq;
                rd_pw_o    = tbl_q[i].pw;
                rd_burst_o = tbl_q[i].burst;
            end
            if (tbl_q[i].en) begin
                any_en_o  = 1'b1;
                low_idx_o = CHW'(i);
                if (CHW'(i) > ch_i) begin
                    nxt_vld_o = 1'b1;
                    nxt_idx_o = CHW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/znd_scan_seq.sv
// Probe firing scheduler: walks enabled channels, fires a burst, then waits for acquisition.
// Two cycles from run to generator release; acq_done gates each advance, bounded by ACQ_TO.
module znd_scan_seq
    import znd_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int ACQ_TO = ACQ_TO_DEF
) (
    input  logic           clk250,
    input  logic           rst_n,
    input  logic           run,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_addr,
    input  logic [FW-1:0]  cfg_frq,
    input  logic [FW-1:0]  cfg_pw,
    input  logic [FW-1:0]  cfg_burst,
    input  logic           cfg_en,
    input  logic           clk_znd,
    input  logic           acq_done,
    output logic           gen_sync_n,
    output logic [FW-1:0]  frq_div,
    output logic [FW-1:0]  pw,
    output logic [CHW-1:0] ch_sel,
    output logic           acq_start,
    output logic           busy,
    output logic           frame_done,
    output logic           err_to
);

    znd_state_e     state_q, state_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [CHW-1:0] sel_q, sel_d;
    logic [FW-1:0]  frq_q, frq_d;
    logic [FW-1:0]  pw_q, pw_d;
    logic [FW-1:0]  bt_q, bt_d;
    logic [FW-1:0]  bcnt_q, bcnt_d;
    logic [TOW-1:0] tcnt_q, tcnt_d;
    logic           err_q, err_d;
    logic           acq_start_q, acq_start_d;

    logic [FW-1:0]  rd_frq, rd_pw, rd_burst;
    logic           nxt_vld, any_en;
    logic [CHW-1:0] nxt_idx, low_idx;
    znd_ent_t       wdat;

    assign wdat = '{frq: cfg_frq, pw: cfg_pw, burst: cfg_burst, en: cfg_en};

    znd_ch_tbl #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_tbl (
        .clk250     (clk250),
        .rst_n      (rst_n),
        .we_i       (cfg_we),
        .waddr_i    (cfg_addr),
        .wdat_i     (wdat),
        .ch_i       (ch_q),
        .rd_frq_o   (rd_frq),
        .rd_pw_o    (rd_pw),
        .rd_burst_o (rd_burst),
        .nxt_vld_o  (nxt_vld),
        .nxt_idx_o  (nxt_idx),
        .low_idx_o  (low_idx),
        .any_en_o   (any_en)
    );

    always_ff @(posedge clk250 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            sel_q       <= '0;
            frq_q       <= '0;
            pw_q        <= '0;
            bt_q        <= '0;
            bcnt_q      <= '0;
            tcnt_q      <= '0;
            err_q       <= 1'b0;
            acq_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            sel_q       <= sel_d;
            frq_q       <= frq_d;
            pw_q        <= pw_d;
            bt_q        <= bt_d;
            bcnt_q      <= bcnt_d;
            tcnt_q      <= tcnt_d;
            err_q       <= err_d;
            acq_start_q <= acq_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        sel_d       = sel_q;
        frq_d       = frq_q;
        pw_d        = pw_q;
        bt_d        = bt_q;
        bcnt_d      = bcnt_q;
        tcnt_d      = tcnt_q;
        err_d       = err_q;
        acq_start_d = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run && any_en) begin
                    err_d   = 1'b0;
                    ch_d    = low_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                frq_d   = rd_frq;
                pw_d    = rd_pw;
                sel_d   = ch_q;
                bt_d    = burst_tgt(rd_burst);
                bcnt_d  = '0;
                state_d = FIRE;
            end
            FIRE: begin
                if (clk_znd) begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_d == bt_q) begin
                        acq_start_d = 1'b1;
                        tcnt_d      = '0;
                        state_d     = WAIT_ACQ;
                    end
                end
            end
            WAIT_ACQ: begin
                // acq_done wins over a timeout landing in the same cycle.
                if (acq_done) begin
                    state_d = NEXT;
                end else if (tcnt_q == TOW'(ACQ_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = NEXT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            NEXT: begin
                if (nxt_vld) begin
                    if (run) begin
                        ch_d    = nxt_idx;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    frame_done = 1'b1;
                    if (run && any_en) begin
                        ch_d    = low_idx;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gen_sync_n = (state_q == FIRE);
    assign busy       = (state_q != IDLE);
    assign acq_start  = acq_start_q;
    assign frq_div    = frq_q;
    assign pw         = pw_q;
    assign ch_sel     = sel_q;
    assign err_to     = err_q;

endmodule

// File: tb/tb_znd_scan_seq.sv
// Directed bench for znd_scan_seq: a phase-level model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_znd_scan_seq;

    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int ACQ = 16;
    localparam int P_IDLE = 0, P_LOAD = 1, P_FIRE = 2, P_WAIT = 3, P_NEXT = 4;

    logic           clk250;
    logic           rst_n;
    logic           run;
    logic           cfg_we;
    logic [CHW-1:0] cfg_addr;
    logic [7:0]     cfg_frq, cfg_pw, cfg_burst;
    logic           cfg_en;
    logic           clk_znd;
    logic           acq_done;
    logic           gen_sync_n;
    logic [7:0]     frq_div, pw;
    logic [CHW-1:0] ch_sel;
    logic           acq_start, busy, frame_done, err_to;

    znd_scan_seq #(.NCH(NCH), .CHW(CHW), .ACQ_TO(ACQ)) dut (
        .clk250     (clk250),
        .rst_n      (rst_n),
        .run        (run),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_frq    (cfg_frq),
        .cfg_pw     (cfg_pw),
        .cfg_burst  (cfg_burst),
        .cfg_en     (cfg_en),
        .clk_znd    (clk_znd),
        .acq_done   (acq_done),
        .gen_sync_n (gen_sync_n),
        .frq_div    (frq_div),
        .pw         (pw),
        .ch_sel     (ch_sel),
        .acq_start  (acq_start),
        .busy       (busy),
        .frame_done (frame_done),
        .err_to     (err_to)
    );

    initial begin
        clk250 = 1'b0;
        forever #2 clk250 = ~clk250;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int znd_per = 10;
    int acq_lat = 12;

    // Behavioural model: the table and the phase of the current channel.
    int t_frq [NCH], t_pw [NCH], t_burst [NCH], t_en [NCH];
    int m_ph, m_cur, m_frq, m_pw, m_sel, m_need, m_got, m_waited;
    bit m_err;

    int as_cnt = 0, fd_cnt = 0, strb_cnt = 0, busy_cnt = 0;
    int as_cyc = 0, fd_cyc = 0;
    bit gen_prev = 1'b0;
    int ch_seq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int m_lowest();
        for (int i = 0; i < NCH; i++) if (t_en[i] != 0) return i;
        return -1;
    endfunction

    function automatic int m_above(input int c);
        for (int i = c + 1; i < NCH; i++) if (t_en[i] != 0) return i;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            t_frq[i] = 0; t_pw[i] = 0; t_burst[i] = 0; t_en[i] = 0;
        end
        m_ph = P_IDLE; m_cur = 0; m_frq = 0; m_pw = 0; m_sel = 0;
        m_need = 1; m_got = 0; m_waited = 0; m_err = 1'b0;
    endtask

    task automatic m_step();
        int nx, lo;
        nx = m_above(m_cur);
        lo = m_lowest();
        case (m_ph)
            P_IDLE: if (run && lo >= 0) begin m_err = 1'b0; m_cur = lo; m_ph = P_LOAD; end
            P_LOAD: begin
                m_frq = t_frq[m_cur]; m_pw = t_pw[m_cur]; m_sel = m_cur;
                m_need = (t_burst[m_cur] == 0) ? 1 : t_burst[m_cur];
                m_got = 0; m_ph = P_FIRE;
            end
            P_FIRE: if (clk_znd) begin
                m_got++;
                if (m_got == m_need) begin m_ph = P_WAIT; m_waited = 0; end
            end
            P_WAIT: begin
                m_waited++;
                if (acq_done) m_ph = P_NEXT;
                else if (m_waited == ACQ) begin m_err = 1'b1; m_ph = P_NEXT; end
            end
            default: begin
                if (nx >= 0 && run) begin m_cur = nx; m_ph = P_LOAD; end
                else if (nx < 0 && run && lo >= 0) begin m_cur = lo; m_ph = P_LOAD; end
                else m_ph = P_IDLE;
            end
        endcase
        if (cfg_we) begin
            t_frq[cfg_addr] = cfg_frq; t_pw[cfg_addr] = cfg_pw;
            t_burst[cfg_addr] = cfg_burst; t_en[cfg_addr] = cfg_en;
        end
    endtask

    // Strobe source standing in for the generator; ignored by the DUT outside FIRE.
    initial begin
        int zc;
        zc = 0;
        clk_znd = 1'b0;
        forever begin
            @(posedge clk250); #1;
            zc++;
            if (zc >= znd_per) begin clk_znd = 1'b1; zc = 0; end
            else clk_znd = 1'b0;
        end
    end

    // Receiver: answers acq_start after acq_lat cycles; acq_lat==0 never answers.
    initial begin
        acq_done = 1'b0;
        forever begin
            @(negedge clk250);
            if (acq_start === 1'b1 && acq_lat > 0) begin
                repeat (acq_lat) @(posedge clk250);
                #1 acq_done = 1'b1;
                @(posedge clk250); #1 acq_done = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    task automatic nsamp();
        @(negedge clk250); #1;
    endtask

    task automatic wr(input int a, input int f, input int p, input int b, input int e);
        @(posedge clk250); #1;
        cfg_we = 1'b1; cfg_addr = CHW'(a);
        cfg_frq = 8'(f); cfg_pw = 8'(p); cfg_burst = 8'(b); cfg_en = e[0];
        @(posedge clk250); #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        do begin nsamp(); n++; end while (busy !== 1'b0 && n < budget);
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_gen(input string nm, input int budget);
        int n;
        n = 0;
        do begin nsamp(); n++; end while (gen_sync_n !== 1'b1 && n < budget);
        chk(nm, {31'd0, gen_sync_n}, 32'd1);
    endtask

    task automatic wait_seq(input string nm, input int want, input int budget);
        int n;
        n = 0;
        while (ch_seq.size() < want && n < budget) begin nsamp(); n++; end
        chk(nm, 32'(ch_seq.size() >= want), 32'd1);
    endtask

    function automatic int seq_at(input int i);
        return (i < ch_seq.size()) ? ch_seq[i] : -1;
    endfunction

    initial begin
        int b_as, b_fd, b_st, b_busy, b_seq;
        rst_n = 1'b0; run = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_frq = '0; cfg_pw = '0; cfg_burst = '0; cfg_en = 1'b0;
        m_reset();

        fork
            forever begin
                logic [22:0] act_v, exp_v;
                @(negedge clk250);
                cyc++;
                if (acq_start === 1'b1) begin as_cnt++; as_cyc = cyc; end
                if (frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
                if (gen_sync_n === 1'b1 && clk_znd) strb_cnt++;
                if (gen_sync_n === 1'b1 && !gen_prev) ch_seq.push_back(int'(ch_sel));
                gen_prev = (gen_sync_n === 1'b1);
                if (busy === 1'b1) busy_cnt++;
                if (!rst_n) m_reset();
                act_v = {gen_sync_n, busy, acq_start, frame_done, err_to, ch_sel, frq_div, pw};
                exp_v = {m_ph == P_FIRE, m_ph != P_IDLE, (m_ph == P_WAIT && m_waited == 0),
                         (m_ph == P_NEXT && m_above(m_cur) < 0), m_err,
                         CHW'(m_sel), 8'(m_frq), 8'(m_pw)};
                chk("cycle_outputs", {9'd0, act_v}, {9'd0, exp_v});
                if (rst_n) m_step();
            end
        join_none

        // Reset, then run with an empty table.
        repeat (2) nsamp();
        chk("rst_gen", {31'd0, gen_sync_n}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frq", {24'd0, frq_div}, 32'd0);
        @(posedge clk250); #1 rst_n = 1'b1;
        b_busy = busy_cnt; b_as = as_cnt;
        run = 1'b1;
        repeat (10) nsamp();
        chk("empty_busy", 32'(busy_cnt - b_busy), 32'd0);
        chk("empty_acq_start", 32'(as_cnt - b_as), 32'd0);
        @(posedge clk250); #1 run = 1'b0;

        // Single channel pass with a short run pulse.
        wr(1, 9, 3, 3, 1);
        b_as = as_cnt; b_fd = fd_cnt; b_st = strb_cnt;
        @(posedge clk250); #1 run = 1'b1;
        nsamp();
        nsamp();
        chk("lat_load_gen", {31'd0, gen_sync_n}, 32'd0);
        nsamp();
        chk("lat_fire_gen", {31'd0, gen_sync_n}, 32'd1);
        repeat (2) @(posedge clk250);
        #1 run = 1'b0;
        wait_idle("single_idle", 200);
        chk("single_ch_sel", 32'(ch_sel), 32'd1);
        chk("single_frq", 32'(frq_div), 32'd9);
        chk("single_pw", 32'(pw), 32'd3);
        chk("single_strobes", 32'(strb_cnt - b_st), 32'd3);
        chk("single_acq_start", 32'(as_cnt - b_as), 32'd1);
        chk("single_frame_done", 32'(fd_cnt - b_fd), 32'd1);

        // Skip a disabled channel and wrap into a second pass.
        znd_per = 3; acq_lat = 2;
        wr(0, 4, 2, 2, 1);
        wr(1, 0, 0, 0, 0);
        wr(2, 5, 1, 1, 1);
        wr(3, 6, 2, 2, 1);
        b_seq = ch_seq.size(); b_fd = fd_cnt;
        @(posedge clk250); #1 run = 1'b1;
        wait_seq("multi_seq_len", b_seq + 5, 600);
        chk("multi_seq0", 32'(seq_at(b_seq + 0)), 32'd0);
        chk("multi_seq1", 32'(seq_at(b_seq + 1)), 32'd2);
        chk("multi_seq2", 32'(seq_at(b_seq + 2)), 32'd3);
        chk("multi_seq3", 32'(seq_at(b_seq + 3)), 32'd0);
        chk("multi_seq4", 32'(seq_at(b_seq + 4)), 32'd2);
        chk("multi_frame_done", 32'(fd_cnt - b_fd), 32'd1);
        run = 1'b0;
        wait_idle("multi_idle", 300);
        chk("multi_frame_done_end", 32'(fd_cnt - b_fd), 32'd1);

        // Zero burst fires once; no acq_done forces a timeout.
        znd_per = 4; acq_lat = 0;
        wr(2, 5, 1, 1, 0);
        wr(3, 6, 2, 2, 0);
        wr(0, 7, 1, 0, 1);
        b_as = as_cnt; b_fd = fd_cnt; b_st = strb_cnt;
        @(posedge clk250); #1 run = 1'b1;
        repeat (3) nsamp();
        run = 1'b0;
        wait_idle("to_idle", 200);
        chk("to_strobes", 32'(strb_cnt - b_st), 32'd1);
        chk("to_acq_start", 32'(as_cnt - b_as), 32'd1);
        chk("to_frame_done", 32'(fd_cnt - b_fd), 32'd1);
        chk("to_wait_len", 32'(fd_cyc - as_cyc), 32'd16);
        chk("to_err", {31'd0, err_to}, 32'd1);
        repeat (5) nsamp();
        chk("to_err_sticky", {31'd0, err_to}, 32'd1);
        @(posedge clk250); #1 run = 1'b1;
        nsamp();
        chk("to_err_idle", {31'd0, err_to}, 32'd1);
        nsamp();
        chk("to_err_cleared", {31'd0, err_to}, 32'd0);
        @(posedge clk250); #1 run = 1'b0;
        wait_idle("to_idle2", 200);
        chk("to_err_again", {31'd0, err_to}, 32'd1);

        // Edits while ch0 fires: its divider waits for the next LOAD, ch2 drops out now.
        acq_lat = 2; znd_per = 3;
        wr(0, 10, 2, 4, 1);
        wr(2, 20, 3, 1, 1);
        wr(3, 30, 4, 1, 1);
        b_seq = ch_seq.size();
        @(posedge clk250); #1 run = 1'b1;
        wait_gen("edit_fire", 50);
        chk("edit_frq_first", 32'(frq_div), 32'd10);
        wr(0, 50, 2, 4, 1);
        wr(2, 20, 3, 1, 0);
        nsamp();
        chk("edit_still_fire", {31'd0, gen_sync_n}, 32'd1);
        chk("edit_frq_held", 32'(frq_div), 32'd10);
        wait_seq("edit_seq_len", b_seq + 3, 400);
        chk("edit_seq0", 32'(seq_at(b_seq + 0)), 32'd0);
        chk("edit_seq1", 32'(seq_at(b_seq + 1)), 32'd3);
        chk("edit_seq2", 32'(seq_at(b_seq + 2)), 32'd0);
        chk("edit_frq_new", 32'(frq_div), 32'd50);
        run = 1'b0;
        wait_idle("edit_idle", 300);

        // Asynchronous reset in the middle of FIRE.
        @(posedge clk250); #1 run = 1'b1;
        wait_gen("arst_fire", 50);
        @(posedge clk250); #1 rst_n = 1'b0;
        #1;
        chk("arst_gen", {31'd0, gen_sync_n}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_acq_start", {31'd0, acq_start}, 32'd0);
        chk("arst_frq", 32'(frq_div), 32'd0);
        @(posedge clk250); #1 rst_n = 1'b1;
        b_busy = busy_cnt;
        repeat (20) nsamp();
        chk("arst_quiet", 32'(busy_cnt - b_busy), 32'd0);
        run = 1'b0;
        repeat (2) nsamp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
